// File: rtl/hdmi_pkg.sv
`timescale 1ns/1ps
// Shared 720p display constants, pixel widths, fetch FSM encoding, nibble expander.
// Latency: n/a (declarations only).
// Backpressure: n/a.
package hdmi_pkg;

  localparam int H_ACTIVE_720P = 1280;
  localparam int V_ACTIVE_720P = 720;
  localparam int POS_W         = 12;
  localparam int RGB444_W      = 12;
  localparam int RGB888_W      = 24;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    FETCH = 2'd1,
    DRAIN = 2'd2
  } fetch_state_t;

  // RGB444 -> RGB888 by nibble replication, so 4'hF maps to full-scale 8'hFF
  function automatic logic [RGB888_W-1:0] expand444(input logic [RGB444_W-1:0] p);
    return {p[11:8], p[11:8], p[7:4], p[7:4], p[3:0], p[3:0]};
  endfunction

endpackage

// File: rtl/fb_dpram.sv
`timescale 1ns/1ps
// Simple dual-port RAM: one write port, one synchronous read port, read-first.
// Latency: read data valid one clock after the address is presented.
// Backpressure: none; out-of-range writes are dropped.
module fb_dpram #(
  parameter int DEPTH = 57600,
  parameter int AW    = 16,
  parameter int DW    = 12
) (
  input  logic          clk,
  input  logic          we,
  input  logic [AW-1:0] wa,
  input  logic [DW-1:0] wd,
  input  logic [AW-1:0] ra,
  output logic [DW-1:0] rd
);

  localparam logic [AW:0] DEPTH_W = (AW+1)'(DEPTH);

  logic [DW-1:0] mem [DEPTH];

  // Guarded write plus registered read; a same-address collision returns the old word
  always_ff @(posedge clk) begin
    if (we && ({1'b0, wa} < DEPTH_W)) begin
      mem[wa] <= wd;
    end
    rd <= mem[ra];
  end

endmodule

// File: rtl/hdmi_fb_reader.sv
`timescale 1ns/1ps
// Upscaling frame-buffer pixel source: returns RGB888 for the hdmi (h_pos, v_pos).
// Latency: data is combinational from h_pos (zero cycles); line refill takes FB_W+1 cycles.
// Backpressure: none; a refill overlapping active video sets the sticky underrun flag.
module hdmi_fb_reader
  import hdmi_pkg::*;
#(
  parameter int H_ACTIVE   = H_ACTIVE_720P,
  parameter int V_ACTIVE   = V_ACTIVE_720P,
  parameter int SCALE_LOG2 = 2,
  parameter int FB_W       = H_ACTIVE >> SCALE_LOG2,
  parameter int FB_H       = V_ACTIVE >> SCALE_LOG2,
  parameter int ADDR_W     = 16
) (
  input  logic                clk_pix,
  input  logic                rst_n,
  input  logic [POS_W-1:0]    h_pos,
  input  logic [POS_W-1:0]    v_pos,
  output logic [RGB888_W-1:0] data,
  input  logic                wr_en,
  input  logic [ADDR_W-1:0]   wr_addr,
  input  logic [RGB444_W-1:0] wr_data,
  output logic                fetch_busy,
  output logic                underrun
);

  localparam int                LB_AW    = $clog2(FB_W);
  localparam logic [POS_W-1:0]  H_LAST   = POS_W'(H_ACTIVE - 1);
  localparam logic [POS_W-1:0]  V_LAST   = POS_W'(V_ACTIVE - 1);
  localparam logic [POS_W-1:0]  SUB_MASK = POS_W'((1 << SCALE_LOG2) - 1);
  localparam logic [LB_AW-1:0]  COL_LAST = LB_AW'(FB_W - 1);
  localparam logic [ADDR_W-1:0] FB_W_A   = ADDR_W'(FB_W);

  fetch_state_t        state, state_nxt;
  logic [ADDR_W-1:0]   base;
  logic [LB_AW-1:0]    col_rd;
  logic                primed;
  logic [RGB444_W-1:0] linebuf [FB_W];
  logic [RGB444_W-1:0] rd_dat;
  logic [ADDR_W-1:0]   rd_addr;
  logic [POS_W-1:0]    v_nxt;
  logic                trigger;
  logic [ADDR_W-1:0]   row_base;
  logic                lb_we;
  logic [LB_AW-1:0]    lb_wa;
  logic [LB_AW-1:0]    lb_ra;
  logic                set_primed;

  fb_dpram #(
    .DEPTH (FB_W * FB_H),
    .AW    (ADDR_W),
    .DW    (RGB444_W)
  ) u_fb (
    .clk (clk_pix),
    .we  (wr_en),
    .wa  (wr_addr),
    .wd  (wr_data),
    .ra  (rd_addr),
    .rd  (rd_dat)
  );

  // Refill at the last active pixel of a line whose successor starts a new source row;
  // the last line of the frame always reloads row 0 so the row index never reaches FB_H
  always_comb begin
    v_nxt    = v_pos + POS_W'(1);
    trigger  = (state == IDLE) && (h_pos == H_LAST) &&
               ((v_pos == V_LAST) || ((v_nxt & SUB_MASK) == '0));
    row_base = (v_pos == V_LAST) ? '0 : ADDR_W'(v_nxt >> SCALE_LOG2) * FB_W_A;
  end

  // Fetch FSM state register
  always_ff @(posedge clk_pix or negedge rst_n) begin
    if (!rst_n) begin
      state <= IDLE;
    end else begin
      state <= state_nxt;
    end
  end

  // Fetch FSM next state; line-buffer writes trail the RAM reads by one cycle
  always_comb begin
    state_nxt  = state;
    rd_addr    = base + ADDR_W'(col_rd);
    lb_we      = 1'b0;
    lb_wa      = col_rd - LB_AW'(1);
    set_primed = 1'b0;
    unique case (state)
      IDLE: begin
        if (trigger) state_nxt = FETCH;
      end
      FETCH: begin
        lb_we = (col_rd != '0);
        if (col_rd == COL_LAST) state_nxt = DRAIN;
      end
      DRAIN: begin
        lb_we      = 1'b1;
        lb_wa      = COL_LAST;
        set_primed = 1'b1;
        state_nxt  = IDLE;
      end
      default: state_nxt = IDLE;
    endcase
  end

  // Fetch address/column counters, primed flag and sticky underrun
  always_ff @(posedge clk_pix or negedge rst_n) begin
    if (!rst_n) begin
      base     <= '0;
      col_rd   <= '0;
      primed   <= 1'b0;
      underrun <= 1'b0;
    end else begin
      if (trigger) begin
        base   <= row_base;
        col_rd <= '0;
      end else if ((state == FETCH) && (col_rd != COL_LAST)) begin
        col_rd <= col_rd + LB_AW'(1);
      end
      if (set_primed) primed <= 1'b1;
      if (fetch_busy && (h_pos != '0)) underrun <= 1'b1;
    end
  end

  // Line buffer is LUT RAM: no reset, written only by the fetch FSM
  always_ff @(posedge clk_pix) begin
    if (lb_we) linebuf[lb_wa] <= rd_dat;
  end

  // Same-cycle pixel lookup; black until the first complete refill
  always_comb begin
    lb_ra      = LB_AW'(h_pos >> SCALE_LOG2);
    fetch_busy = (state != IDLE);
    data       = primed ? expand444(linebuf[lb_ra]) : '0;
  end

endmodule

// File: tb/tb_hdmi_fb_reader.sv
`timescale 1ns/1ps
module tb_hdmi_fb_reader;

  logic        clk_pix = 1'b0;
  logic        rst_n   = 1'b0;
  logic [11:0] h_pos   = '0;
  logic [11:0] v_pos   = '0;
  logic [23:0] data;
  logic        wr_en   = 1'b0;
  logic [15:0] wr_addr = '0;
  logic [11:0] wr_data = '0;
  logic        fetch_busy;
  logic        underrun;

  int n_cmp = 0;
  int n_err = 0;

  logic [11:0] model [640];

  always #5 clk_pix = ~clk_pix;

  hdmi_fb_reader dut (
    .clk_pix    (clk_pix),
    .rst_n      (rst_n),
    .h_pos      (h_pos),
    .v_pos      (v_pos),
    .data       (data),
    .wr_en      (wr_en),
    .wr_addr    (wr_addr),
    .wr_data    (wr_data),
    .fetch_busy (fetch_busy),
    .underrun   (underrun)
  );

  function automatic logic [23:0] exp_rgb(input logic [11:0] p);
    logic [7:0] r, g, b;
    r = 8'(p[11:8]) * 8'h11;
    g = 8'(p[7:4]) * 8'h11;
    b = 8'(p[3:0]) * 8'h11;
    return {r, g, b};
  endfunction

  task automatic chk(input string tag, input logic [23:0] obs, input logic [23:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  task automatic step(input int h, input int v);
    @(posedge clk_pix);
    #1;
    h_pos = 12'(h);
    v_pos = 12'(v);
    #1;
  endtask

  // bounded: always returns after 400 cycles, counting busy cycles
  task automatic run_refill(input int hh, output int busy_cnt);
    busy_cnt = 0;
    for (int i = 0; i < 400; i++) begin
      step(hh, 0);
      if (fetch_busy) busy_cnt++;
    end
  endtask

  initial begin
    int cnt;
    int c2;

    for (int i = 0; i < 640; i++) model[i] = 12'(i * 37 + 5);
    model[0]   = 12'hF0A;
    model[639] = 12'h123;

    // reset state
    #2;
    chk("rst_data", data, 24'h000000);
    chk("rst_busy", 24'(fetch_busy), 24'd0);
    chk("rst_underrun", 24'(underrun), 24'd0);
    @(posedge clk_pix);
    @(posedge clk_pix);
    #1;
    rst_n = 1'b1;

    // load rows 0 and 1 of the frame buffer
    for (int i = 0; i < 640; i++) begin
      @(posedge clk_pix);
      #1;
      wr_en   = 1'b1;
      wr_addr = 16'(i);
      wr_data = model[i];
    end
    @(posedge clk_pix);
    #1;
    wr_en = 1'b0;

    // unprimed: black; no trigger mid-row
    step(640, 360);
    chk("unprimed_mid", data, 24'h000000);
    step(1279, 1);
    step(0, 1);
    chk("no_trig_v1", 24'(fetch_busy), 24'd0);

    // first refill at (1279, 719)
    step(1279, 719);
    chk("unprimed_trig", data, 24'h000000);
    chk("trig_not_yet_busy", 24'(fetch_busy), 24'd0);
    step(0, 0);
    chk("busy_after_trig", 24'(fetch_busy), 24'd1);
    cnt = 1;
    run_refill(0, c2);
    chk("refill_len_first", 24'(cnt + c2), 24'd321);
    chk("idle_after_refill", 24'(fetch_busy), 24'd0);

    // row 0 replicated 4x horizontally
    for (int h = 0; h < 4; h++) begin
      step(h, 0);
      chk("row0_px0", data, 24'hFF00AA);
    end
    step(4, 0);
    chk("row0_px4", data, 24'h0022AA);
    step(1276, 3);
    chk("row0_col319_v3", data, exp_rgb(model[319]));

    // row 1 loaded at end of v_pos=3
    step(1279, 3);
    run_refill(0, c2);
    chk("refill_len_row1", 24'(c2), 24'd321);
    for (int h = 1276; h < 1280; h++) begin
      step(h, 4);
      chk("row1_col319_v4", data, 24'h112233);
    end
    step(0, 4);
    chk("row1_col0_v4", data, exp_rgb(model[320]));
    step(1279, 5);
    chk("row1_col319_v5", data, 24'h112233);
    step(1279, 6);
    chk("row1_col319_v6", data, 24'h112233);
    step(1276, 7);
    chk("row1_col319_v7", data, 24'h112233);
    step(0, 7);
    chk("no_trig_v6", 24'(fetch_busy), 24'd0);

    // CPU rewrites row 0 in lockstep with the fetch: fetch sees old data
    step(1279, 719);
    c2 = 0;
    for (int i = 0; i < 400; i++) begin
      @(posedge clk_pix);
      #1;
      h_pos = '0;
      v_pos = '0;
      if (i < 320) begin
        wr_en   = 1'b1;
        wr_addr = 16'(i);
        wr_data = ~model[i];
      end else begin
        wr_en = 1'b0;
      end
      #1;
      if (fetch_busy) c2++;
    end
    chk("refill_len_collide", 24'(c2), 24'd321);
    chk("collide_no_underrun", 24'(underrun), 24'd0);
    step(0, 0);
    chk("collide_old_px0", data, 24'hFF00AA);
    step(4, 0);
    chk("collide_old_px4", data, 24'h0022AA);
    step(1279, 0);
    chk("collide_old_px1279", data, 24'hEE2200);
    for (int i = 0; i < 320; i++) model[i] = ~model[i];
    step(1279, 719);
    run_refill(0, c2);
    step(0, 0);
    chk("new_px0", data, 24'h00FF55);
    step(1279, 0);
    chk("new_px1279", data, 24'h11DDFF);

    // underrun: active pixels during a refill
    step(1279, 719);
    run_refill(1, c2);
    chk("underrun_set", 24'(underrun), 24'd1);
    step(1279, 719);
    run_refill(0, c2);
    chk("underrun_sticky", 24'(underrun), 24'd1);

    // async reset mid-fetch
    step(1279, 719);
    for (int i = 0; i < 10; i++) step(0, 0);
    chk("midfetch_busy", 24'(fetch_busy), 24'd1);
    @(posedge clk_pix);
    #1;
    rst_n = 1'b0;
    #1;
    chk("arst_busy", 24'(fetch_busy), 24'd0);
    chk("arst_data", data, 24'h000000);
    chk("arst_underrun", 24'(underrun), 24'd0);
    @(posedge clk_pix);
    #1;
    rst_n = 1'b1;
    step(0, 0);
    chk("post_rst_black", data, 24'h000000);
    chk("post_rst_idle", 24'(fetch_busy), 24'd0);
    step(1279, 719);
    run_refill(0, c2);
    chk("refill_len_resume", 24'(c2), 24'd321);
    step(0, 0);
    chk("resume_px0", data, 24'h00FF55);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
